// File: rtl/md_unit_ctrl.sv
// Multiply/divide unit controller: sequences MULT/DIV with a countdown, commits HI/LO,
// performs MTHI/MTLO writes and raises a D-stage stall request on MDU hazards.
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_req
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [31:0] r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
    logic        r_pend_wr, w_pend_wr_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;

    logic        w_accept;
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_div_sgn, w_neg_a, w_neg_b;
    logic [31:0] w_mag_a, w_mag_b, w_dvsr, w_quo_mag, w_rem_mag, w_quo, w_rem;

    assign w_accept = start & ~flush & (r_state == ST_IDLE);

    // Low 64 bits of a product are sign-agnostic once operands are extended to 64 bits.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow and a zero divisor.
    assign w_div_sgn = (op == 3'd2);
    assign w_neg_a   = w_div_sgn & a[31];
    assign w_neg_b   = w_div_sgn & b[31];
    assign w_mag_a   = w_neg_a ? neg32(a) : a;
    assign w_mag_b   = w_neg_b ? neg32(b) : b;
    assign w_dvsr    = (b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_quo_mag = w_mag_a / w_dvsr;
    assign w_rem_mag = w_mag_a % w_dvsr;
    assign w_quo     = (w_neg_a ^ w_neg_b) ? neg32(w_quo_mag) : w_quo_mag;
    assign w_rem     = w_neg_a ? neg32(w_rem_mag) : w_rem_mag;

    // Next-state and register-input logic for the controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (op)
                        3'd0, 3'd1: begin
                            w_pend_hi_nxt = (op == 3'd0) ? w_prod_s[63:32] : w_prod_u[63:32];
                            w_pend_lo_nxt = (op == 3'd0) ? w_prod_s[31:0]  : w_prod_u[31:0];
                            w_pend_wr_nxt = 1'b1;
                            w_cnt_nxt     = MULT_LOAD;
                            w_state_nxt   = ST_BUSY;
                            w_busy_nxt    = 1'b1;
                        end
                        3'd2, 3'd3: begin
                            w_pend_hi_nxt = w_rem;
                            w_pend_lo_nxt = w_quo;
                            w_pend_wr_nxt = (b != 32'd0);
                            w_cnt_nxt     = DIV_LOAD;
                            w_state_nxt   = ST_BUSY;
                            w_busy_nxt    = 1'b1;
                        end
                        3'd4:    w_hi_nxt = a;
                        3'd5:    w_lo_nxt = a;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end else begin
                        w_hi_nxt = r_hi;
                    end
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Controller state and architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign stall_req = md_use_d & (r_busy | (start & ~flush & (op <= 3'd3)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus pushes expected commits, a monitor pops on done.
module tb_md_unit_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        md_use_d = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, stall_req;

    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .md_use_d(md_use_d), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        q_exp[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          busy_run = 0;
    logic        prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] ch, input logic [31:0] cl);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        sx = int'(x);
        sy = int'(y);
        ux = 64'(x);
        uy = 64'(y);
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {ch, cl};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return {ch, cl};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return {ch, cl};
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever the DUT reports a commit.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                chk("done_width", 64'(prev_done), 64'd0);
                if (q_exp.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q_exp.pop_front();
                    chk("commit_hi", 64'(hi), 64'(e.hi));
                    chk("commit_lo", 64'(lo), 64'(e.lo));
                    chk("busy_len", 64'(busy_run), 64'(e.len));
                end
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] r;
        if (o <= 3'd3) begin
            r     = ref_res(o, x, y, m_hi, m_lo);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.len = (o <= 3'd1) ? MC : DC;
            q_exp.push_back(e);
            m_hi  = e.hi;
            m_lo  = e.lo;
        end else if (o == 3'd4) begin
            m_hi = x;
        end else if (o == 3'd5) begin
            m_lo = x;
        end
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 40 && done !== 1'b1; k++) @(negedge clk);
        chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        do_op(o, x, y);
        if (o <= 3'd3) begin
            wait_done();
        end else begin
            chk("mt_busy", 64'(busy), 64'd0);
            chk("mt_hi", 64'(hi), 64'(m_hi));
            chk("mt_lo", 64'(lo), 64'(m_lo));
        end
    endtask

    initial begin
        int          dones;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        reset = 1'b1;
        md_use_d = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi", 64'(hi), 64'h0000_0002);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2);
        chk("divu_hi", 64'(hi), 64'd1);
        chk("divu_lo", 64'(lo), 64'd3);

        run_op(3'd4, 32'h1234, 32'd0);
        run_op(3'd5, 32'h5678, 32'd0);
        run_op(3'd2, 32'd99, 32'd0);
        chk("div0_hi", 64'(hi), 64'h1234);
        chk("div0_lo", 64'(lo), 64'h5678);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_hi", 64'd0, 64'(hi));
        chk("divovf_lo", 64'(lo), 64'h8000_0000);

        // Flushed MULT and MTHI: nothing starts, no stall, nothing written.
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9; flush = 1'b1;
        #1;
        chk("flush_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        chk("flush_busy", 64'(busy), 64'd0);
        op = 3'd4; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_busy2", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'(m_hi));
        chk("flush_lo", 64'(lo), 64'(m_lo));
        run_op(3'd6, 32'hAAAA_AAAA, 32'd1);
        run_op(3'd7, 32'h5555_5555, 32'd1);

        // DIV with a hazarding D-stage instruction and an ignored mid-op MULT.
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'hFFFF_FFFD;
        #1;
        chk("stall_issue", 64'(stall_req), 64'd1);
        do_op(3'd2, 32'd1000, 32'hFFFF_FFFD);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            chk("stall_busy", 64'(stall_req), 64'd1);
            if (i == 3) begin
                start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        chk("stall_done_seen", 64'(done), 64'd1);
        chk("stall_after", 64'(stall_req), 64'd0);
        chk("ignored_hi", 64'(hi), 64'hFFFF_FFFF & 64'(m_hi));
        md_use_d = 1'b0;

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb);
        end

        // Reset during busy cycle 3 of a MULT: immediate clear, no later commit.
        do_op(3'd0, 32'h0001_0003, 32'h0007_0011);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        q_exp.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("post_rst_done", 64'(dones), 64'd0);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_lo", 64'(lo), 64'd0);
        chk("queue_empty", 64'(q_exp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
